// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the hazard controller state encoding.
package pipe_pkg;

    localparam int unsigned     REG_W  = 5;
    localparam logic [REG_W-1:0] REG_X0 = '0;

    typedef logic [1:0] hz_state_t;

    localparam hz_state_t S_RUN      = 2'd0;
    localparam hz_state_t S_MEM_WAIT = 2'd1;
    localparam hz_state_t S_FLUSH    = 2'd2;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, stall/flush/redirect controls and counters out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [pipe_pkg::REG_W-1:0] ID_rs1;
    logic [pipe_pkg::REG_W-1:0] ID_rs2;
    logic                       ID_use_rs1;
    logic                       ID_use_rs2;
    logic                       ID_EX_memread;
    logic [pipe_pkg::REG_W-1:0] ID_EX_rd;
    logic                       ID_EX_branch;
    logic                       ID_EX_take;
    logic                       EX_take;
    logic                       mem_busy;

    logic                       PC_write;
    logic                       IF_ID_stall;
    logic                       IF_ID_flush;
    logic                       EX_stall;
    logic                       EX_flush;
    logic                       redirect;
    logic [CNT_W-1:0]           stall_cnt;
    logic [CNT_W-1:0]           flush_cnt;

    // Pipeline side
    modport master (
        output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_EX_memread, ID_EX_rd,
               ID_EX_branch, ID_EX_take, EX_take, mem_busy,
        input  PC_write, IF_ID_stall, IF_ID_flush, EX_stall, EX_flush, redirect,
               stall_cnt, flush_cnt
    );

    // Controller side
    modport slave (
        input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_EX_memread, ID_EX_rd,
               ID_EX_branch, ID_EX_take, EX_take, mem_busy,
        output PC_write, IF_ID_stall, IF_ID_flush, EX_stall, EX_flush, redirect,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;

    // Count enabled cycles, hold once saturated
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, memory-wait freeze, mispredict redirect/flush.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);

    hz_state_t  state_q, state_d;
    logic [1:0] fc_q, fc_d;
    logic       pm_q, pm_d;

    logic lu, mp, flush_inc;
    logic pc_write, if_id_stall, if_id_flush, ex_stall, ex_flush, redirect;

    assign lu = hz.ID_EX_memread && (hz.ID_EX_rd != REG_X0) &&
                ((hz.ID_use_rs1 && (hz.ID_rs1 == hz.ID_EX_rd)) ||
                 (hz.ID_use_rs2 && (hz.ID_rs2 == hz.ID_EX_rd)));
    assign mp = hz.ID_EX_branch && (hz.ID_EX_take != hz.EX_take);

    // Next state and raw controls; mem_busy beats mispredict beats load-use
    always_comb begin
        state_d     = state_q;
        fc_d        = fc_q;
        pm_d        = pm_q;
        flush_inc   = 1'b0;
        pc_write    = 1'b1;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        ex_stall    = 1'b0;
        ex_flush    = 1'b0;
        redirect    = 1'b0;

        if (hz.mem_busy) begin
            pc_write    = 1'b0;
            if_id_stall = 1'b1;
            ex_stall    = 1'b1;
            state_d     = S_MEM_WAIT;
            fc_d        = 2'd0;
            // Only a fresh entry from RUN latches the EX mispredict; a wait keeps it
            if (state_q == S_RUN) begin
                pm_d = mp;
            end else if (state_q == S_FLUSH) begin
                pm_d = 1'b0;
            end
        end else if (state_q == S_FLUSH) begin
            if_id_flush = 1'b1;
            ex_flush    = 1'b1;
            fc_d        = fc_q - 2'd1;
            if (fc_q <= 2'd1) begin
                state_d = S_RUN;
            end
        end else begin
            // RUN, or the release cycle of MEM_WAIT (pm_q is always 0 in RUN)
            state_d = S_RUN;
            pm_d    = 1'b0;
            if (mp || pm_q) begin
                redirect    = 1'b1;
                if_id_flush = 1'b1;
                ex_flush    = 1'b1;
                flush_inc   = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    fc_d    = 2'(FLUSH_CYCLES - 1);
                    state_d = S_FLUSH;
                end
            end else if (lu) begin
                pc_write    = 1'b0;
                if_id_stall = 1'b1;
                ex_flush    = 1'b1;
            end
        end
    end

    // Flush wins over stall on the same pipeline register
    assign hz.PC_write    = pc_write;
    assign hz.IF_ID_stall = if_id_stall & ~if_id_flush;
    assign hz.IF_ID_flush = if_id_flush;
    assign hz.EX_stall    = ex_stall & ~ex_flush;
    assign hz.EX_flush    = ex_flush;
    assign hz.redirect    = redirect;

    // FSM, flush countdown and pending-mispredict registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            fc_q    <= 2'd0;
            pm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            pm_q    <= pm_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (~pc_write),
        .q    (hz.stall_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (flush_inc),
        .q    (hz.flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a cycle-kind reference model.
module tb_hazard_ctrl;

    localparam int FC  = 2;
    localparam int MAX = 65535;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) bus ();
    hazard_ctrl_if #(.CNT_W(4))  bus_s ();

    hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (bus)
    );

    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut_s (
        .clk  (clk),
        .reset(reset),
        .hz   (bus_s)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: what kind of cycle the pipeline sees, derived from the hazard rules
    typedef enum int {K_RUN, K_BUBBLE, K_REDIRECT, K_FLUSHING, K_FREEZE} kind_e;
    bit m_wait, m_pend, n_wait, n_pend;
    int m_left, m_stall, m_flush, n_left, n_stall, n_flush;
    logic [5:0] exp_ctl; // {PC_write, IF_ID_stall, IF_ID_flush, EX_stall, EX_flush, redirect}

    function automatic logic [5:0] got_ctl();
        return {bus.PC_write, bus.IF_ID_stall, bus.IF_ID_flush, bus.EX_stall, bus.EX_flush,
                bus.redirect};
    endfunction

    task automatic model_reset();
        m_wait = 0; m_pend = 0; m_left = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_eval();
        bit lu_m, mp_m, take;
        kind_e k;
        lu_m = bus.ID_EX_memread && (int'(bus.ID_EX_rd) != 0) &&
               ((bus.ID_use_rs1 && bus.ID_rs1 == bus.ID_EX_rd) ||
                (bus.ID_use_rs2 && bus.ID_rs2 == bus.ID_EX_rd));
        mp_m = bus.ID_EX_branch && (bus.ID_EX_take != bus.EX_take);
        n_wait = m_wait; n_pend = m_pend; n_left = m_left; n_stall = m_stall; n_flush = m_flush;
        if (bus.mem_busy) begin
            k = K_FREEZE;
            if (!m_wait) n_pend = (m_left == 0) ? mp_m : 1'b0;
            n_wait = 1; n_left = 0;
        end else if (m_left > 0) begin
            k = K_FLUSHING;
            n_left = m_left - 1;
        end else begin
            take = mp_m || (m_wait && m_pend);
            n_wait = 0; n_pend = 0;
            if (take) begin
                k = K_REDIRECT;
                n_left = FC - 1;
                if (m_flush < MAX) n_flush = m_flush + 1;
            end else if (lu_m) begin
                k = K_BUBBLE;
            end else begin
                k = K_RUN;
            end
        end
        if ((k == K_FREEZE || k == K_BUBBLE) && m_stall < MAX) n_stall = m_stall + 1;
        case (k)
            K_FREEZE:   exp_ctl = 6'b010100;
            K_BUBBLE:   exp_ctl = 6'b010010;
            K_REDIRECT: exp_ctl = 6'b101011;
            K_FLUSHING: exp_ctl = 6'b101010;
            default:    exp_ctl = 6'b100000;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        m_wait = n_wait; m_pend = n_pend; m_left = n_left; m_stall = n_stall; m_flush = n_flush;
        @(negedge clk);
    endtask

    task automatic idle();
        bus.ID_rs1 = '0; bus.ID_rs2 = '0; bus.ID_use_rs1 = 0; bus.ID_use_rs2 = 0;
        bus.ID_EX_memread = 0; bus.ID_EX_rd = '0; bus.ID_EX_branch = 0;
        bus.ID_EX_take = 0; bus.EX_take = 0; bus.mem_busy = 0;
        bus_s.ID_rs1 = '0; bus_s.ID_rs2 = '0; bus_s.ID_use_rs1 = 0; bus_s.ID_use_rs2 = 0;
        bus_s.ID_EX_memread = 0; bus_s.ID_EX_rd = '0; bus_s.ID_EX_branch = 0;
        bus_s.ID_EX_take = 0; bus_s.EX_take = 0; bus_s.mem_busy = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            #1;
            tests_run++;
            if (got_ctl() !== 6'b100000) begin
                tests_failed++;
                $display("FAIL reset_ctl phase=%0d: got %b want 100000", p, got_ctl());
            end
            tests_run++;
            if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0 ||
                bus_s.stall_cnt !== 4'd0 || bus_s.flush_cnt !== 4'd0) begin
                tests_failed++;
                $display("FAIL reset_cnt phase=%0d: got %0d/%0d %0d/%0d want 0", p,
                         bus.stall_cnt, bus.flush_cnt, bus_s.stall_cnt, bus_s.flush_cnt);
            end
            tests_run++;
            if (bus_s.PC_write !== 1'b1 || bus_s.EX_flush !== 1'b0 || bus_s.redirect !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_ctl_s phase=%0d: got pc=%b exf=%b rd=%b want 1 0 0", p,
                         bus_s.PC_write, bus_s.EX_flush, bus_s.redirect);
            end
            @(negedge clk);
            reset = 1'b0;
        end
    endtask

    task automatic test_load_use();
        logic [4:0] rds [3] = '{5'd5, 5'd0, 5'd5};
        bit         uses[3] = '{1'b1, 1'b1, 1'b0};
        logic [5:0] want;
        int base;
        for (int v = 0; v < 3; v++) begin
            base = m_stall;
            for (int c = 0; c < 2; c++) begin
                idle();
                if (c == 0) begin
                    bus.ID_EX_memread = 1; bus.ID_EX_rd = rds[v];
                    bus.ID_rs2 = 5'd5; bus.ID_use_rs2 = uses[v];
                    bus.ID_rs1 = 5'($urandom_range(0, 31));
                end
                #1 model_eval();
                want = (c == 0 && v == 0) ? 6'b010010 : 6'b100000;
                tests_run++;
                if (got_ctl() !== want || got_ctl() !== exp_ctl) begin
                    tests_failed++;
                    $display("FAIL load_use v=%0d c=%0d: got %b want %b", v, c, got_ctl(), want);
                end
                tick();
            end
            tests_run++;
            if (bus.stall_cnt !== 16'(base + ((v == 0) ? 1 : 0))) begin
                tests_failed++;
                $display("FAIL load_use_cnt v=%0d: got %0d want %0d", v, bus.stall_cnt,
                         base + ((v == 0) ? 1 : 0));
            end
        end
    endtask

    task automatic test_mispredict();
        logic [5:0] want[3] = '{6'b101011, 6'b101010, 6'b100000};
        int base;
        base = m_flush;
        for (int c = 0; c < 3; c++) begin
            idle();
            if (c == 0) begin
                bus.ID_EX_branch = 1; bus.ID_EX_take = 0; bus.EX_take = 1;
            end
            #1 model_eval();
            tests_run++;
            if (got_ctl() !== want[c] || got_ctl() !== exp_ctl) begin
                tests_failed++;
                $display("FAIL mispredict c=%0d: got %b want %b", c, got_ctl(), want[c]);
            end
            tick();
        end
        tests_run++;
        if (bus.flush_cnt !== 16'(base + 1)) begin
            tests_failed++;
            $display("FAIL mispredict_cnt: got %0d want %0d", bus.flush_cnt, base + 1);
        end
    endtask

    task automatic test_mem_wait();
        int base;
        base = m_stall;
        for (int c = 0; c < 6; c++) begin
            idle();
            bus.mem_busy = (c < 4);
            #1 model_eval();
            tests_run++;
            if (got_ctl() !== ((c < 4) ? 6'b010100 : 6'b100000) || got_ctl() !== exp_ctl) begin
                tests_failed++;
                $display("FAIL mem_wait c=%0d: got %b want %b", c, got_ctl(), exp_ctl);
            end
            tick();
        end
        tests_run++;
        if (bus.stall_cnt !== 16'(base + 4)) begin
            tests_failed++;
            $display("FAIL mem_wait_cnt: got %0d want %0d", bus.stall_cnt, base + 4);
        end
    endtask

    task automatic test_mp_during_busy();
        logic [5:0] want[6] = '{6'b010100, 6'b010100, 6'b010100, 6'b101011, 6'b101010, 6'b100000};
        int base;
        base = m_flush;
        for (int c = 0; c < 6; c++) begin
            idle();
            bus.mem_busy = (c < 3);
            if (c == 0) begin
                bus.ID_EX_branch = 1; bus.ID_EX_take = 1; bus.EX_take = 0;
            end
            #1 model_eval();
            tests_run++;
            if (got_ctl() !== want[c] || got_ctl() !== exp_ctl) begin
                tests_failed++;
                $display("FAIL mp_busy c=%0d: got %b want %b", c, got_ctl(), want[c]);
            end
            tick();
            if (c == 2 || c == 3) begin
                tests_run++;
                if (bus.flush_cnt !== 16'(base + c - 2)) begin
                    tests_failed++;
                    $display("FAIL mp_busy_cnt c=%0d: got %0d want %0d", c, bus.flush_cnt,
                             base + c - 2);
                end
            end
        end
    endtask

    task automatic test_lu_and_mp();
        int base;
        base = m_stall;
        idle();
        bus.ID_EX_memread = 1; bus.ID_EX_rd = 5'd7; bus.ID_rs1 = 5'd7; bus.ID_use_rs1 = 1;
        bus.ID_EX_branch = 1; bus.ID_EX_take = 0; bus.EX_take = 1;
        #1 model_eval();
        tests_run++;
        if (got_ctl() !== 6'b101011 || got_ctl() !== exp_ctl) begin
            tests_failed++;
            $display("FAIL lu_mp: got %b want 101011", got_ctl());
        end
        tick();
        idle();
        #1 model_eval();
        tick();
        tests_run++;
        if (bus.stall_cnt !== 16'(base)) begin
            tests_failed++;
            $display("FAIL lu_mp_cnt: got %0d want %0d", bus.stall_cnt, base);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.ID_rs1        = 5'($urandom_range(0, 3));
            bus.ID_rs2        = 5'($urandom_range(0, 3));
            bus.ID_use_rs1    = 1'($urandom);
            bus.ID_use_rs2    = 1'($urandom);
            bus.ID_EX_memread = 1'($urandom);
            bus.ID_EX_rd      = 5'($urandom_range(0, 3));
            bus.ID_EX_branch  = ($urandom_range(0, 9) < 3);
            bus.ID_EX_take    = 1'($urandom);
            bus.EX_take       = 1'($urandom);
            bus.mem_busy      = ($urandom_range(0, 4) == 0);
            #1 model_eval();
            tests_run++;
            if (got_ctl() !== exp_ctl) begin
                tests_failed++;
                $display("FAIL random_ctl c=%0d: got %b want %b", c, got_ctl(), exp_ctl);
            end
            tests_run++;
            if (bus.stall_cnt !== 16'(m_stall) || bus.flush_cnt !== 16'(m_flush)) begin
                tests_failed++;
                $display("FAIL random_cnt c=%0d: got %0d/%0d want %0d/%0d", c, bus.stall_cnt,
                         bus.flush_cnt, m_stall, m_flush);
            end
            tick();
        end
        idle();
        for (int c = 0; c < 4; c++) begin
            #1 model_eval();
            tick();
        end
    endtask

    task automatic test_saturation();
        int want;
        for (int c = 0; c < 21; c++) begin
            idle();
            bus_s.mem_busy = (c < 20);
            #1;
            @(posedge clk);
            @(negedge clk);
            want = (c + 1 < 15) ? c + 1 : 15;
            tests_run++;
            if (bus_s.stall_cnt !== 4'(want)) begin
                tests_failed++;
                $display("FAIL saturate c=%0d: got %0d want %0d", c, bus_s.stall_cnt, want);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        idle();
        bus.ID_EX_branch = 1; bus.ID_EX_take = 1; bus.EX_take = 0;
        #1 model_eval();
        tick();
        idle();
        #1;
        tests_run++;
        if (got_ctl() !== 6'b101010) begin
            tests_failed++;
            $display("FAIL mid_flush_pre: got %b want 101010", got_ctl());
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (got_ctl() !== 6'b100000 || bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_flush_reset: got %b %0d/%0d want 100000 0/0", got_ctl(),
                     bus.stall_cnt, bus.flush_cnt);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #1 model_eval();
        tests_run++;
        if (got_ctl() !== 6'b100000 || got_ctl() !== exp_ctl) begin
            tests_failed++;
            $display("FAIL mid_flush_after: got %b want 100000", got_ctl());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mispredict();
        test_mem_wait();
        test_mp_during_busy();
        test_lu_and_mp();
        test_random();
        test_saturation();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller. It generates the stall, flush and PC-write controls for the PC, the IF/ID register and the ID/EX register, which exposes `EX_stall`/`EX_flush`. It resolves three hazards:
- load-use dependencies (one bubble),
- multi-cycle data-memory waits (full freeze),
- branch mispredictions detected in EX (redirect plus flush).

It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 1: cycles of front-end flush after a mispredict, range 1–3.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `ID_rs1`, `ID_rs2` in 5 each: source registers of the instruction in ID.
- `ID_use_rs1`, `ID_use_rs2` in 1 each: the ID instruction actually reads that source.
- `ID_EX_memread` in 1: the instruction in EX is a load.
- `ID_EX_rd` in 5: destination register of the instruction in EX.
- `ID_EX_branch` in 1: a branch is resolving in EX this cycle.
- `ID_EX_take` in 1: predicted direction of that branch.
- `EX_take` in 1: actual direction of that branch.
- `mem_busy` in 1: data memory is not ready; MEM cannot complete.
- `PC_write` out 1: PC may update.
- `IF_ID_stall` out 1: hold IF/ID.
- `IF_ID_flush` out 1: clear IF/ID.
- `EX_stall` out 1: hold ID/EX.
- `EX_flush` out 1: clear ID/EX.
- `redirect` out 1: select the resolved branch target as next PC.
- `stall_cnt` out CNT_W: cycles in which `PC_write` = 0.
- `flush_cnt` out CNT_W: mispredicts accepted.

## Operation
- States: S_RUN, S_MEM_WAIT, S_FLUSH. Registers: state, flush counter `fc` (2 bits), pending-mispredict flag `pm`, and the two perf counters.
- Signal definitions:
  - `lu` = `ID_EX_memread` & (`ID_EX_rd` != 0) & ((`ID_use_rs1` & `ID_rs1` == `ID_EX_rd`) | (`ID_use_rs2` & `ID_rs2` == `ID_EX_rd`)).
  - `mp` = `ID_EX_branch` & (`ID_EX_take` != `EX_take`).
- Priority within a cycle: `mem_busy` > `mp` > `lu` > normal flow.
- S_RUN:
  - If `mem_busy`: `PC_write`=0, `IF_ID_stall`=1, `EX_stall`=1. Set `pm`=`mp`. Go to S_MEM_WAIT.
  - Else if `mp`: `redirect`=1, `PC_write`=1, `IF_ID_flush`=1, `EX_flush`=1. Increment `flush_cnt`. If `FLUSH_CYCLES`>1, load `fc`=`FLUSH_CYCLES`-1 and go to S_FLUSH.
  - Else if `lu`: `PC_write`=0, `IF_ID_stall`=1, `EX_flush`=1 (bubble). Stay in S_RUN. The bubble clears `ID_EX_memread`, so the stall lasts exactly one cycle.
  - Else all controls are inactive and `PC_write`=1.
- S_MEM_WAIT:
  - Full freeze: `PC_write`=0, `IF_ID_stall`=1, `EX_stall`=1. `mp` is ignored because the EX contents are frozen.
  - On the first cycle with `mem_busy`=0: if `pm`=1, apply the S_RUN mispredict action and clear `pm`. Otherwise apply the normal S_RUN rules, including `lu`. Then follow the S_RUN transitions.
- S_FLUSH:
  - `IF_ID_flush`=1, `EX_flush`=1, `PC_write`=1, `redirect`=0. Decrement `fc`.
  - Return to S_RUN when `fc` reaches 1→0 and the cycle completes.
  - `mem_busy` here takes priority: go to S_MEM_WAIT, and `fc` is discarded.
- Flush and stall asserted together on the same register: flush wins. This matches the ID/EX priority.
- Counters saturate at all-ones and never wrap.
  - `stall_cnt` increments on every cycle with `PC_write`=0.
  - `flush_cnt` increments once per accepted mispredict. A mispredict latched in `pm` is counted when it is applied, not when it is latched.

## Timing
- All control outputs are combinational from state and current inputs. They are valid before the clock edge at which the pipeline registers sample.
- State, `fc`, `pm` and the counters update on posedge `clk`.
- Load-use costs exactly 1 cycle. A mispredict costs `FLUSH_CYCLES` flush cycles. A memory wait costs N cycles for N cycles of `mem_busy`.
- Reset (asynchronous, mid-operation allowed): state=S_RUN, `fc`=0, `pm`=0, both counters=0.
- Output values while reset is held and immediately after: `PC_write`=1, all stall/flush/redirect=0 (given idle inputs).
- Any pending mispredict is dropped on reset.

## Structure
- Shared package `pipe_pkg` holds:
  - state encoding `hz_state_t` (2 bits);
  - the register-index width constant (5) and the x0 index constant.
- One sub-module `sat_counter` (parameter W; ports `clk`, `reset`, `inc`, `q`), instantiated twice.

## Test plan
- `lw x5` in EX (`ID_EX_memread`=1, `ID_EX_rd`=5); ID has `ID_rs2`=5, `ID_use_rs2`=1 -> exactly 1 cycle with `PC_write`=0, `IF_ID_stall`=1, `EX_flush`=1; `stall_cnt`=1. Same stimulus with `ID_EX_rd`=0 or `ID_use_rs2`=0 -> no stall.
- `ID_EX_branch`=1, `ID_EX_take`=0, `EX_take`=1, `FLUSH_CYCLES`=2 -> cycle 0: `redirect`=1 with both flushes; cycle 1: both flushes, `redirect`=0; cycle 2: run. `flush_cnt`=1.
- `mem_busy`=1 for 4 cycles -> `PC_write`=0, `IF_ID_stall`=1, `EX_stall`=1 for exactly those 4 cycles; `stall_cnt`=4; resume on cycle 5.
- Mispredict coincident with `mem_busy` rising, busy 3 cycles -> 3 freeze cycles, then on the first non-busy cycle `redirect`=1 with both flushes; `flush_cnt`=1 only after application.
- Load-use and mispredict in the same cycle -> mispredict action only; no `IF_ID_stall`; `stall_cnt` unchanged.
- Preload `stall_cnt` near all-ones with `CNT_W`=4: 20 busy cycles -> `stall_cnt`=15 holds. Reset asserted mid S_FLUSH -> outputs return to the idle values immediately and the counters read 0.
